// File: rtl/sobel_line_server_pkg.sv
// Shared constants and types for the Sobel line server: read FSM encoding,
// default geometry, and the buffer reader/writer constants.
package sobel_line_server_pkg;

  localparam int DEF_LINE_W  = 320;
  localparam int DEF_FRAME_H = 240;
  localparam int DEF_PX_W    = 15;

  // Buffer writer/reader share a ping-pong pair of line banks.
  localparam int BUF_NUM_BANKS = 2;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACK    = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_server_line_bank_ram.sv
// One line of pixel storage: single write port, single registered read port.
module line_bank_ram #(
  parameter int DEPTH  = 320,
  parameter int WIDTH  = 15,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sobel_line_server.sv
// Ping-pong line buffer between the capture side and sobel_control: fills
// lines as pixels arrive and streams whole lines on request, oldest first.
module sobel_line_server
  import sobel_line_server_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int PX_W    = DEF_PX_W
) (
  input  logic            sobel_clk,
  input  logic            reset,
  input  logic [PX_W-1:0] in_px_gray,
  input  logic            in_px_valid,
  input  logic            read_req,
  output logic            ack_read,
  output logic [PX_W-1:0] px_gray_out,
  output logic            px_out_valid,
  output logic            frame_done,
  output logic            overflow
);

  localparam int COL_W  = clog2_min1(LINE_W);
  localparam int LCNT_W = clog2_min1(FRAME_H);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_W - 1);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(FRAME_H - 1);

  rd_state_e                state_q, state_d;
  logic [BUF_NUM_BANKS-1:0] full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]         wr_col_q, wr_col_d;
  logic                     overflow_q, overflow_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [COL_W-1:0]         rd_col_q, rd_col_d;
  logic [LCNT_W-1:0]        line_cnt_q, line_cnt_d;
  logic                     frame_done_q, frame_done_d;

  logic             wr_en;
  logic             rd_en;
  logic             last_px;
  logic [COL_W-1:0] rd_addr;
  logic [PX_W-1:0]  bank_rdata [BUF_NUM_BANKS];

  always_comb begin
    wr_en      = in_px_valid && !full_q[wr_bank_q] && !reset;
    wr_bank_d  = wr_bank_q;
    wr_col_d   = wr_col_q;
    overflow_d = overflow_q | (in_px_valid & full_q[wr_bank_q]);
    if (wr_en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
  end

  // rd_col counts the pixel being presented; the RAM is addressed one ahead.
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_col_d     = rd_col_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    last_px      = 1'b0;
    ack_read     = 1'b0;
    px_out_valid = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (read_req && full_q[rd_bank_q]) state_d = RD_ACK;
      end
      RD_ACK: begin
        ack_read = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_col_d = '0;
        state_d  = RD_STREAM;
      end
      RD_STREAM: begin
        px_out_valid = 1'b1;
        if (rd_col_q == LAST_COL) begin
          last_px   = 1'b1;
          rd_col_d  = '0;
          rd_bank_d = ~rd_bank_q;
          state_d   = RD_IDLE;
          if (line_cnt_q == LAST_LINE) begin
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + LCNT_W'(1);
          end
        end else begin
          rd_en    = 1'b1;
          rd_addr  = rd_col_q + COL_W'(1);
          rd_col_d = rd_col_q + COL_W'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Writer sets and reader clears always land on different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (wr_en && (wr_col_q == LAST_COL)) full_d[wr_bank_q] = 1'b1;
    if (last_px) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge sobel_clk) begin
    if (reset) begin
      state_q      <= RD_IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      wr_col_q     <= '0;
      overflow_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_col_q     <= '0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_col_q     <= wr_col_d;
      overflow_q   <= overflow_d;
      rd_bank_q    <= rd_bank_d;
      rd_col_q     <= rd_col_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar gi = 0; gi < BUF_NUM_BANKS; gi++) begin : g_bank
    line_bank_ram #(
      .DEPTH  (LINE_W),
      .WIDTH  (PX_W),
      .ADDR_W (COL_W)
    ) u_ram (
      .clk   (sobel_clk),
      .we    (wr_en && (wr_bank_q == 1'(gi))),
      .waddr (wr_col_q),
      .wdata (in_px_gray),
      .re    (rd_en && (rd_bank_q == 1'(gi))),
      .raddr (rd_addr),
      .rdata (bank_rdata[gi])
    );
  end

  assign px_gray_out = px_out_valid ? bank_rdata[rd_bank_q] : '0;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/sobel_line_server.md
SOBEL_LINE_SERVER -- requirements
Module: sobel_line_server

Interface
REQ-001 Parameter LINE_W, default 320, pixels per line.
REQ-002 Parameter FRAME_H, default 240, lines per frame.
REQ-003 Parameter PX_W, default 15, gray pixel width.
REQ-004 sobel_clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_px_gray  input  PX_W  incoming gray pixel from capture side.
REQ-007 in_px_valid  input  1  in_px_gray valid this cycle.
REQ-008 read_req  input  1  sobel_control requests next line.
REQ-009 ack_read  output  1  one-cycle grant; line stream starts next cycle.
REQ-010 px_gray_out  output  PX_W  streamed pixel to sobel_control.
REQ-011 px_out_valid  output  1  px_gray_out valid this cycle.
REQ-012 frame_done  output  1  one-cycle pulse after last pixel of line FRAME_H-1 is streamed.
REQ-013 overflow  output  1  sticky; a pixel was dropped because both banks were full.

Function
REQ-014 Storage SHALL be two line banks (ping-pong), each LINE_W x PX_W, each with a full flag.
REQ-015 Fill side: on in_px_valid with the write bank not full, store the pixel at wr_col and increment wr_col.
REQ-016 When wr_col = LINE_W-1 is written, set that bank's full flag, toggle wr_bank, and reset wr_col to 0.
REQ-017 in_px_valid while the write bank is full: drop the pixel, hold wr_col, and set overflow (stays 1 until reset).
REQ-018 Read FSM states: IDLE, ACK, STREAM.
REQ-019 IDLE -> ACK when read_req=1 and bank rd_bank is full; otherwise remain in IDLE, with read_req ignored.
REQ-020 ACK: ack_read=1 for exactly this cycle; issue memory read of rd_col=0; go to STREAM.
REQ-021 STREAM: px_out_valid=1 for exactly LINE_W consecutive cycles, carrying pixels 0..LINE_W-1 of rd_bank in order (1-cycle registered read latency).
REQ-022 On the last STREAM cycle: clear rd_bank full flag, toggle rd_bank, increment line_cnt, return to IDLE.
REQ-023 If line_cnt was FRAME_H-1, pulse frame_done on the cycle after the last pixel, and wrap line_cnt to 0.
REQ-024 read_req changes during ACK or STREAM SHALL be ignored; a stream is never aborted.
REQ-025 Lines SHALL be served oldest-first; rd_bank and wr_bank alternate independently.
REQ-026 Same-cycle full-flag set (writer) and clear (reader) on different banks SHALL both take effect; the writer never targets a full bank, so a same-bank conflict cannot occur.
REQ-027 px_gray_out SHALL hold 0 whenever px_out_valid=0.
REQ-028 Minimum gap between successive ack_read pulses SHALL be LINE_W+1 cycles.

Reset
REQ-029 On reset=1, the following SHALL be 0 on the next edge: ack_read, px_out_valid, px_gray_out, frame_done, overflow, both full flags, wr_bank, wr_col, rd_bank, rd_col, line_cnt.
REQ-030 On reset, the FSM SHALL go to IDLE, including mid-stream.
REQ-031 Bank memory contents SHALL NOT be reset.
REQ-032 Inputs during the reset cycle SHALL be ignored.

Structure
REQ-033 The FSM state encoding and the LINE_W/FRAME_H/PX_W defaults SHALL live in the shared common package, next to the buffer_reader/buffer_writer constants.
REQ-034 One sub-module, line_bank_ram (single write port, single registered read port, depth LINE_W), SHALL be instantiated twice.
REQ-035 The memory SHALL be inferable as block RAM.

Verification (bench overrides LINE_W=8, FRAME_H=3)
REQ-036 Single line: feed 8 pixels (values 1..8), then read_req=1 -> ack_read pulses once, px_out_valid high for 8 cycles, px_gray_out 1..8 in order.
REQ-037 Ping-pong: feed 16 pixels (lines A=10..17, B=20..27) before any read_req -> two grants stream A then B, with no overflow.
REQ-038 Overflow: feed 17 pixels with no read_req -> 17th pixel dropped, overflow=1 and sticky; the following stream still returns 10..17.
REQ-039 Frame wrap: stream 3 lines -> frame_done pulses once, one cycle after the 3rd line's last pixel; line_cnt returns to 0.
REQ-040 Early request: read_req=1 with no full bank -> no ack_read until the 8th pixel is written, then ack_read on the following cycle.
REQ-041 Reset mid-stream: assert reset at the 4th streamed pixel -> next edge all outputs 0, FSM IDLE; a fresh 8-pixel fill streams correctly afterwards.
